// File: rtl/fifo_burst_arb.sv
// fifo_burst_arb
//   Drains two byte-wide FIFOs (normal, non show-ahead read side) into one
//   shared sink. The arbiter grants one channel, reads up to BURST_LEN bytes
//   from it, then re-arbitrates. A channel holding fewer than BURST_LEN bytes
//   is still served once it has waited TIMEOUT cycles.
//
//   Build macro STRICT_PRIO_EN: when defined, channel 0 always wins when it is
//   eligible and the round-robin pointer is ignored. Channel 1 still gets its
//   timeout. When undefined (default), grants alternate round-robin.
//
//   Handshake: chN_rdreq pops one byte from FIFO N and that byte is on chN_q
//   in the following cycle. A read is issued only in a cycle where b_rdy is 1,
//   so the beat shown with data_out_vld=1 in cycle t+1 was authorised by
//   b_rdy in cycle t. A presented beat is never held or retried.
//
//   dbg_state exposes the FSM state (0 IDLE, 1 BURST, 2 DRAIN).
module fifo_burst_arb #(
   parameter int DW        = 8,
   parameter int AW        = 6,
   parameter int BURST_LEN = 8,
   parameter int TIMEOUT   = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ch0_empty,
   input  logic [AW-1:0] ch0_usedw,
   input  logic [DW-1:0] ch0_q,
   output logic          ch0_rdreq,
   input  logic          ch1_empty,
   input  logic [AW-1:0] ch1_usedw,
   input  logic [DW-1:0] ch1_q,
   output logic          ch1_rdreq,
   input  logic          b_rdy,
   output logic [DW-1:0] data_out,
   output logic          data_out_vld,
   output logic          data_out_sop,
   output logic          data_out_eop,
   output logic          data_out_ch,
   output logic [1:0]    dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BURST = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   localparam int            WCW         = $clog2(TIMEOUT + 1);
   localparam logic [AW-1:0] BURST_LEN_W = AW'(BURST_LEN);
   localparam logic [WCW-1:0] TIMEOUT_W  = WCW'(TIMEOUT);

   state_t         state;
   state_t         state_nxt;
   logic           g_ch;
   logic           g_ch_nxt;
   logic           last_grant;
   logic           last_grant_nxt;
   logic [AW-1:0]  rem;
   logic [AW-1:0]  rem_nxt;
   logic           first_rd;
   logic           first_rd_nxt;

   logic [WCW-1:0] wait0;
   logic [WCW-1:0] wait1;
   logic           elig0;
   logic           elig1;
   logic           grant_vld;
   logic           grant_ch;
   logic [AW-1:0]  sel_usedw;
   logic [AW-1:0]  grant_len;
   logic           rd_any;
   logic           busy0;
   logic           busy1;
   logic           take0;
   logic           take1;

   logic           beat_vld;
   logic           beat_ch;
   logic           beat_sop;
   logic           beat_eop;

   // Eligibility: a full burst is waiting, or a partial one has timed out.
   always_comb begin
      elig0 = (ch0_usedw >= BURST_LEN_W) || (!ch0_empty && (wait0 == TIMEOUT_W));
      elig1 = (ch1_usedw >= BURST_LEN_W) || (!ch1_empty && (wait1 == TIMEOUT_W));
   end

   // Grant selection; round-robin search starts at the channel after last_grant.
   always_comb begin
      grant_vld = elig0 || elig1;
      grant_ch  = 1'b0;
`ifdef STRICT_PRIO_EN
      grant_ch  = !elig0;
`else
      if (elig0 && elig1) begin
         grant_ch = !last_grant;
      end else begin
         grant_ch = !elig0;
      end
`endif
   end

   // Burst length: min(usedw, BURST_LEN), never below one byte.
   always_comb begin
      sel_usedw = grant_ch ? ch1_usedw : ch0_usedw;
      if (sel_usedw >= BURST_LEN_W) begin
         grant_len = BURST_LEN_W;
      end else if (sel_usedw == '0) begin
         grant_len = AW'(1);
      end else begin
         grant_len = sel_usedw;
      end
   end

   // FSM next state, grant latch and read strobe generation.
   always_comb begin
      state_nxt      = state;
      g_ch_nxt       = g_ch;
      last_grant_nxt = last_grant;
      rem_nxt        = rem;
      first_rd_nxt   = first_rd;
      rd_any         = 1'b0;
      case (state)
         S_IDLE: begin
            if (grant_vld) begin
               g_ch_nxt       = grant_ch;
               last_grant_nxt = grant_ch;
               rem_nxt        = grant_len;
               first_rd_nxt   = 1'b1;
               state_nxt      = S_BURST;
            end
         end
         S_BURST: begin
            // Grant is held through b_rdy stalls; only the read pauses.
            rd_any = b_rdy && (rem != '0);
            if (rd_any) begin
               rem_nxt      = rem - AW'(1);
               first_rd_nxt = 1'b0;
               if (rem == AW'(1)) begin
                  state_nxt = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            // Last read data lands on chN_q during this cycle.
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   assign ch0_rdreq = rd_any && !g_ch;
   assign ch1_rdreq = rd_any &&  g_ch;

   // FSM and grant registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         g_ch       <= 1'b0;
         last_grant <= 1'b1;
         rem        <= '0;
         first_rd   <= 1'b0;
      end else begin
         state      <= state_nxt;
         g_ch       <= g_ch_nxt;
         last_grant <= last_grant_nxt;
         rem        <= rem_nxt;
         first_rd   <= first_rd_nxt;
      end
   end

   // A channel counts as served from the grant decision until the FSM is back in IDLE.
   always_comb begin
      busy0 = (state != S_IDLE) && !g_ch;
      busy1 = (state != S_IDLE) &&  g_ch;
      take0 = (state == S_IDLE) && grant_vld && !grant_ch;
      take1 = (state == S_IDLE) && grant_vld &&  grant_ch;
   end

   // Starvation counters: count while non-empty and unserved, saturate at TIMEOUT.
   always_ff @(posedge clk) begin
      if (rst) begin
         wait0 <= '0;
         wait1 <= '0;
      end else begin
         if (ch0_empty || busy0 || take0) begin
            wait0 <= '0;
         end else if (wait0 != TIMEOUT_W) begin
            wait0 <= wait0 + WCW'(1);
         end
         if (ch1_empty || busy1 || take1) begin
            wait1 <= '0;
         end else if (wait1 != TIMEOUT_W) begin
            wait1 <= wait1 + WCW'(1);
         end
      end
   end

   // Beat framing follows the read strobe by one cycle, aligned with chN_q.
   always_ff @(posedge clk) begin
      if (rst) begin
         beat_vld <= 1'b0;
         beat_ch  <= 1'b0;
         beat_sop <= 1'b0;
         beat_eop <= 1'b0;
      end else begin
         beat_vld <= rd_any;
         if (rd_any) begin
            beat_ch  <= g_ch;
            beat_sop <= first_rd;
            beat_eop <= (rem == AW'(1));
         end else begin
            beat_sop <= 1'b0;
            beat_eop <= 1'b0;
         end
      end
   end

   // FIFO q is already a register; forward it directly, zero when no beat.
   always_comb begin
      data_out = '0;
      if (beat_vld) begin
         data_out = beat_ch ? ch1_q : ch0_q;
      end
   end

   assign data_out_vld = beat_vld;
   assign data_out_sop = beat_sop;
   assign data_out_eop = beat_eop;
   assign data_out_ch  = beat_ch;
   assign dbg_state    = state;

endmodule

// File: tb/tb_fifo_burst_arb.sv
// tb_fifo_burst_arb
//   Two behavioural FIFOs feed the arbiter. Written bytes are recorded per
//   channel; the expected beat stream is built from those records using the
//   burst rules (who is granted, how many bytes, sop/eop) and checked by an
//   independent monitor. Build with +define+STRICT_PRIO_EN to check the
//   fixed-priority variant.
module tb_fifo_burst_arb;

   localparam int DW = 8;
   localparam int AW = 6;
   localparam int BL = 8;
   localparam int TO = 64;
   localparam int EW = DW + 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          ch0_empty = 1'b1;
   logic [AW-1:0] ch0_usedw = '0;
   logic [DW-1:0] ch0_q = '0;
   logic          ch0_rdreq;
   logic          ch1_empty = 1'b1;
   logic [AW-1:0] ch1_usedw = '0;
   logic [DW-1:0] ch1_q = '0;
   logic          ch1_rdreq;
   logic          b_rdy = 1'b1;
   logic [DW-1:0] data_out;
   logic          data_out_vld;
   logic          data_out_sop;
   logic          data_out_eop;
   logic          data_out_ch;
   logic [1:0]    dbg_state;

   int checks = 0;
   int errors = 0;
   int beats_seen = 0;
   int rdy_mode = 0;

   logic [DW-1:0] f0[$];
   logic [DW-1:0] f1[$];
   logic [DW-1:0] pend0[$];
   logic [DW-1:0] pend1[$];
   logic [DW-1:0] mdl0[$];
   logic [DW-1:0] mdl1[$];
   logic [EW-1:0] exp_q[$];
   logic          wr0 = 1'b0;
   logic          wr1 = 1'b0;
   logic [DW-1:0] wd0 = '0;
   logic [DW-1:0] wd1 = '0;
   logic [EW-1:0] mon_got;
   logic [EW-1:0] mon_exp;

   fifo_burst_arb #(.DW(DW), .AW(AW), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
      .clk          (clk),
      .rst          (rst),
      .ch0_empty    (ch0_empty),
      .ch0_usedw    (ch0_usedw),
      .ch0_q        (ch0_q),
      .ch0_rdreq    (ch0_rdreq),
      .ch1_empty    (ch1_empty),
      .ch1_usedw    (ch1_usedw),
      .ch1_q        (ch1_q),
      .ch1_rdreq    (ch1_rdreq),
      .b_rdy        (b_rdy),
      .data_out     (data_out),
      .data_out_vld (data_out_vld),
      .data_out_sop (data_out_sop),
      .data_out_eop (data_out_eop),
      .data_out_ch  (data_out_ch),
      .dbg_state    (dbg_state)
   );

   // Clock.
   always #5 clk = ~clk;

   // Behavioural FIFOs: q registered on read, flags follow the fill level.
   always @(posedge clk) begin
      if (rst) begin
         f0.delete();
         f1.delete();
         ch0_q <= '0;
         ch1_q <= '0;
      end else begin
         if (ch0_rdreq) begin
            checks++;
            if (f0.size() == 0) begin
               errors++;
               $display("FAIL rd_empty ch0 got rdreq=1 required rdreq=0");
            end else begin
               ch0_q <= f0.pop_front();
            end
         end
         if (ch1_rdreq) begin
            checks++;
            if (f1.size() == 0) begin
               errors++;
               $display("FAIL rd_empty ch1 got rdreq=1 required rdreq=0");
            end else begin
               ch1_q <= f1.pop_front();
            end
         end
         if (wr0) f0.push_back(wd0);
         if (wr1) f1.push_back(wd1);
      end
      ch0_usedw <= AW'(f0.size());
      ch1_usedw <= AW'(f1.size());
      ch0_empty <= (f0.size() == 0);
      ch1_empty <= (f1.size() == 0);
   end

   // Write driver: one pending byte per channel per cycle.
   always @(negedge clk) begin
      wr0 = 1'b0;
      wr1 = 1'b0;
      if (!rst && pend0.size() > 0) begin
         wr0 = 1'b1;
         wd0 = pend0.pop_front();
      end
      if (!rst && pend1.size() > 0) begin
         wr1 = 1'b1;
         wd1 = pend1.pop_front();
      end
   end

   // Sink ready driver: 0 always ready, 1 random, 2 held low.
   always @(negedge clk) begin
      case (rdy_mode)
         0:       b_rdy = 1'b1;
         1:       b_rdy = ($urandom_range(0, 3) != 0);
         default: b_rdy = 1'b0;
      endcase
   end

   // Monitor: every presented beat is popped against the expected stream.
   always @(posedge clk) begin
      #1;
      if (!rst && data_out_vld) begin
         mon_got = {data_out_ch, data_out_sop, data_out_eop, data_out};
         checks++;
         beats_seen++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL beat_unexpected got ch=%0d sop=%0d eop=%0d data=%h required no beat",
                     mon_got[EW-1], mon_got[EW-2], mon_got[EW-3], mon_got[DW-1:0]);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_got !== mon_exp) begin
               errors++;
               $display("FAIL beat got ch=%0d sop=%0d eop=%0d data=%h required ch=%0d sop=%0d eop=%0d data=%h",
                        mon_got[EW-1], mon_got[EW-2], mon_got[EW-3], mon_got[DW-1:0],
                        mon_exp[EW-1], mon_exp[EW-2], mon_exp[EW-3], mon_exp[DW-1:0]);
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic chk(input string name, input int got, input int req);
      checks++;
      if (got != req) begin
         errors++;
         $display("FAIL %s got=%0d required=%0d", name, got, req);
      end
   endtask

   // One-cycle reset; all outputs must read zero right after the reset edge.
   task automatic do_reset();
      rst = 1'b1;
      pend0.delete();
      pend1.delete();
      mdl0.delete();
      mdl1.delete();
      exp_q.delete();
      step(1);
      chk("rst_vld",   int'(data_out_vld), 0);
      chk("rst_sop",   int'(data_out_sop), 0);
      chk("rst_eop",   int'(data_out_eop), 0);
      chk("rst_ch",    int'(data_out_ch), 0);
      chk("rst_data",  int'(data_out), 0);
      chk("rst_rd0",   int'(ch0_rdreq), 0);
      chk("rst_rd1",   int'(ch1_rdreq), 0);
      chk("rst_state", int'(dbg_state), 0);
      rst = 1'b0;
   endtask

   // Stimulus: n random bytes into channel ch, remembered for the model.
   task automatic queue_stream(input int ch, input int n);
      logic [DW-1:0] b;
      for (int i = 0; i < n; i++) begin
         b = DW'($urandom_range(0, 255));
         if (ch == 0) begin
            pend0.push_back(b);
            mdl0.push_back(b);
         end else begin
            pend1.push_back(b);
            mdl1.push_back(b);
         end
      end
   endtask

   // Model: a burst of len bytes from the head of channel ch.
   task automatic expect_burst(input int ch, input int len);
      logic [DW-1:0] b;
      logic          c;
      logic          s;
      logic          e;
      c = (ch != 0);
      for (int i = 0; i < len; i++) begin
         b = (ch == 0) ? mdl0.pop_front() : mdl1.pop_front();
         s = (i == 0);
         e = (i == len - 1);
         exp_q.push_back({c, s, e, b});
      end
   endtask

   task automatic wait_done(input string name, input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         step(1);
         n++;
      end
      chk({name, "_left"}, exp_q.size(), 0);
      step(10);
   endtask

   task automatic wait_beats(input string name, input int target, input int budget);
      int n;
      n = 0;
      while (beats_seen < target && n < budget) begin
         step(1);
         n++;
      end
      chk({name, "_reach"}, (beats_seen >= target) ? 1 : 0, 1);
   endtask

   initial begin
      int base;
      rdy_mode = 0;
      step(2);
      do_reset();

      // Single full burst on ch0 while ch1 stays empty.
      queue_stream(0, BL);
      expect_burst(0, BL);
      wait_done("t1", 200);

      // Partial data on ch1 only: served after the timeout, not before.
      do_reset();
      base = beats_seen;
      queue_stream(1, 3);
      expect_burst(1, 3);
      step(55);
      chk("t3_early_beats", beats_seen - base, 0);
      wait_done("t3", 200);

      // Sink stalls for 5 cycles after beat 3.
      do_reset();
      base = beats_seen;
      queue_stream(0, BL);
      expect_burst(0, BL);
      wait_beats("t4", base + 3, 200);
      rdy_mode = 2;
      base = beats_seen;
      step(5);
      chk("t4_stall_extra_le1", (beats_seen - base <= 1) ? 1 : 0, 1);
      rdy_mode = 0;
      wait_done("t4", 200);

      // Reset in the middle of a ch0 burst; ch0 must still win the next grant.
      base = beats_seen;
      queue_stream(0, BL);
      expect_burst(0, BL);
      wait_beats("t5", base + 3, 200);
      do_reset();
      queue_stream(0, BL);
      queue_stream(1, BL);
      expect_burst(0, BL);
      expect_burst(1, BL);
      wait_done("t5", 400);

      // Both channels loaded: bursts alternate (or ch0 first under strict priority).
      for (int it = 0; it < 3; it++) begin
         do_reset();
         rdy_mode = (it == 0) ? 0 : 1;
         queue_stream(0, 4 * BL);
         queue_stream(1, 4 * BL);
`ifdef STRICT_PRIO_EN
         for (int k = 0; k < 4; k++) expect_burst(0, BL);
         for (int k = 0; k < 4; k++) expect_burst(1, BL);
`else
         for (int k = 0; k < 4; k++) begin
            expect_burst(0, BL);
            expect_burst(1, BL);
         end
`endif
         wait_done("t2", 3000);
         rdy_mode = 0;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Watchdog in case the main sequence is ever stuck.
   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
